// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART transmitter/receiver family.
// Parity modes, FSM state encoding and the baud divisor calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: producer-side handshake plus line/status outputs of the transmitter.
// master = word producer, slave = transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_end marks the last clock of each bit.
// restart holds the count at zero so the next bit starts aligned.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_end) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, one word per valid/ready handshake.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     clk_50M,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
        $error("uart_tx_param: illegal parameter set");
    end

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           idx_q, idx_d;
    logic                 bit_end;
    logic                 last_stop;
    logic                 accept;

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .restart (state_q == ST_IDLE),
        .bit_end (bit_end)
    );

    // Ready opens in the final stop clock so a waiting word follows with no gap.
    assign last_stop    = (state_q == ST_STOP) && bit_end && (idx_q == 4'(STOP_BITS - 1));
    assign bus.tx_ready = (state_q == ST_IDLE) || last_stop;
    assign accept       = bus.tx_valid && bus.tx_ready;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_START;
            ST_START: if (bit_end) begin
                state_d = ST_DATA;
                idx_d   = '0;
            end
            ST_DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                if (idx_q == 4'(DATA_BITS - 1)) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP;
                idx_d   = '0;
            end
            ST_STOP: if (bit_end) begin
                if (last_stop) begin
                    state_d = accept ? ST_START : ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            shreg_d = bus.tx_data;
            par_d   = (^bus.tx_data) ^ (PARITY == PAR_ODD);
        end
    end

    always_comb begin
        bus.tx         = 1'b1;
        bus.busy       = (state_q != ST_IDLE);
        bus.frame_done = last_stop;
        unique case (state_q)
            ST_START:  bus.tx = 1'b0;
            ST_DATA:   bus.tx = shreg_q[0];
            ST_PARITY: bus.tx = par_q;
            default:   bus.tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations driven in turn through one mux.
// Expected line levels come from a per-frame bit list built from the word.
module tb_uart_tx_param;
    localparam int CPB = 50000000 / 115200;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50M = ~clk_50M;

    logic [8:0] tb_data  = '0;
    logic       tb_valid = 1'b0;
    int         sel      = 0;
    int         cyc      = 0;
    int         done_cyc = 0;
    int         checks   = 0;
    int         errors   = 0;

    int dbits[4] = '{8, 8, 8, 7};
    int par[4]   = '{0, 1, 2, 0};
    int stops[4] = '{1, 1, 1, 2};

    always @(posedge clk_50M) cyc <= cyc + 1;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_data  = tb_data[7:0];
    assign if1.tx_data  = tb_data[7:0];
    assign if2.tx_data  = tb_data[7:0];
    assign if3.tx_data  = tb_data[6:0];
    assign if0.tx_valid = tb_valid && (sel == 0);
    assign if1.tx_valid = tb_valid && (sel == 1);
    assign if2.tx_valid = tb_valid && (sel == 2);
    assign if3.tx_valid = tb_valid && (sel == 3);

    uart_tx_param #(.PARITY(0)) u0 (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if0.slave));
    uart_tx_param #(.PARITY(1)) u1 (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if1.slave));
    uart_tx_param #(.PARITY(2)) u2 (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if2.slave));
    uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk_50M(clk_50M), .rst_n(rst_n), .bus(if3.slave));

    logic m_tx, m_busy, m_rdy, m_done;
    always_comb begin
        m_tx   = if0.tx;
        m_busy = if0.busy;
        m_rdy  = if0.tx_ready;
        m_done = if0.frame_done;
        case (sel)
            1: begin
                m_tx = if1.tx; m_busy = if1.busy; m_rdy = if1.tx_ready; m_done = if1.frame_done;
            end
            2: begin
                m_tx = if2.tx; m_busy = if2.busy; m_rdy = if2.tx_ready; m_done = if2.frame_done;
            end
            3: begin
                m_tx = if3.tx; m_busy = if3.busy; m_rdy = if3.tx_ready; m_done = if3.frame_done;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [8:0] w, input bit hold, input logic [8:0] nxt);
        int n = 0;
        while (m_rdy !== 1'b1 && n < 20000) begin
            @(negedge clk_50M);
            n++;
        end
        chk("ready_wait", 32'(n < 20000), 1);
        tb_data  = w;
        tb_valid = 1'b1;
        @(posedge clk_50M);
        #1;
        if (hold) begin
            tb_data = nxt;
        end else begin
            tb_valid = 1'b0;
            tb_data  = 9'($urandom);
        end
    endtask

    // Line levels for one frame, expanded from the word by frame rules.
    task automatic check_frame(input logic [8:0] w, input string tag);
        logic bits[$];
        logic p = 1'b0;
        int   n;
        int   bad_tx = 0, bad_busy = 0, bad_done = 0, bad_rdy = 0, ndone = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dbits[sel]; i++) begin
            bits.push_back(w[i]);
            p ^= w[i];
        end
        if (par[sel] != 0) bits.push_back((par[sel] == 2) ? ~p : p);
        for (int i = 0; i < stops[sel]; i++) bits.push_back(1'b1);
        n = bits.size() * CPB;
        for (int j = 0; j < n; j++) begin
            @(negedge clk_50M);
            if (m_tx !== bits[j / CPB]) bad_tx++;
            if (m_busy !== 1'b1) bad_busy++;
            if (m_done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            if (m_done !== (j == n - 1)) bad_done++;
            if (m_rdy !== (j == n - 1)) bad_rdy++;
        end
        chk({tag, "_tx_bad_cycles"}, bad_tx, 0);
        chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
        chk({tag, "_done_bad_cycles"}, bad_done, 0);
        chk({tag, "_ready_bad_cycles"}, bad_rdy, 0);
        chk({tag, "_done_pulses"}, ndone, 1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk_50M);
        chk({tag, "_idle_tx"}, m_tx, 1);
        chk({tag, "_idle_busy"}, m_busy, 0);
        chk({tag, "_idle_ready"}, m_rdy, 1);
        chk({tag, "_idle_done"}, m_done, 0);
    endtask

    logic [8:0] w;
    int         d1;
    int         bad;

    initial begin
        sel      = 0;
        w        = 9'($urandom) & 9'h0FF;
        tb_data  = w;
        tb_valid = 1'b1;
        repeat (3) @(negedge clk_50M);
        chk("rst_tx", m_tx, 1);
        chk("rst_ready", m_rdy, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        rst_n = 1'b1;
        @(posedge clk_50M);
        #1 tb_valid = 1'b0;
        check_frame(w, "first");
        check_idle("first");

        accept(9'h055, 1'b0, 9'h0);
        check_frame(9'h055, "f55");
        check_idle("f55");

        accept(9'h0A5, 1'b1, 9'h03C);
        check_frame(9'h0A5, "b2b_a5");
        d1 = done_cyc;
        accept(9'h03C, 1'b0, 9'h0);
        check_frame(9'h03C, "b2b_3c");
        chk("b2b_done_gap", done_cyc - d1, 10 * CPB);
        check_idle("b2b");

        w = 9'($urandom) & 9'h0FF;
        accept(w, 1'b0, 9'h0);
        check_frame(w, "rand8n1");
        check_idle("rand8n1");

        accept(9'h0F0, 1'b0, 9'h0);
        repeat (4 * CPB + CPB / 2) @(negedge clk_50M);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", m_tx, 1);
        chk("midrst_busy", m_busy, 0);
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        bad = 0;
        repeat (2 * CPB) begin
            @(negedge clk_50M);
            if (m_tx !== 1'b1 || m_busy !== 1'b0) bad++;
        end
        chk("midrst_quiet_cycles", bad, 0);
        accept(9'h012, 1'b0, 9'h0);
        check_frame(9'h012, "f12");
        check_idle("f12");

        for (int s = 1; s < 4; s++) begin
            sel = s;
            @(negedge clk_50M);
            w = (s == 3) ? 9'h041 : 9'h007;
            accept(w, 1'b0, 9'h0);
            check_frame(w, $sformatf("cfg%0d_fixed", s));
            check_idle($sformatf("cfg%0d_fixed", s));
            w = 9'($urandom) & 9'((1 << dbits[s]) - 1);
            accept(w, 1'b0, 9'h0);
            check_frame(w, $sformatf("cfg%0d_rand", s));
            check_idle($sformatf("cfg%0d_rand", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
